// File: rtl/fifo_skid_writer.sv
// Write-side skid stage: turns a valid/ready byte stream into FIFO write strobes.
// Two holding registers keep in_ready registered, so fifo_full never reaches in_ready combinationally.
module fifo_skid_writer #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  fifo_wr_data,
    output logic                   fifo_wr_en,
    input  logic                   fifo_full,
    input  logic                   fifo_ready,
    output logic [1:0]             level,
    output logic [COUNT_WIDTH-1:0] wr_count
);

    // Encoding doubles as the level output (entries held).
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    logic [1:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  head_q, head_d;
    logic [DATA_WIDTH-1:0]  skid_q, skid_d;
    logic                   in_ready_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Write enable depends only on registered state and the FIFO flags.
    assign pop  = (state_q != S_EMPTY) & ~fifo_full & fifo_ready;
    assign push = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_ONE;
                    head_d  = in_data;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    state_d = S_TWO;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = skid_q;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (pop && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_TWO);
            count_q    <= count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign fifo_wr_data = head_q;
    assign fifo_wr_en   = pop;
    assign level        = state_q;
    assign wr_count     = count_q;

endmodule

// File: tb/tb_fifo_skid_writer.sv
// Bench for fifo_skid_writer: directed scenarios plus a randomized stream,
// checked by a queue-based buffer model sampled on the falling clock edge.
module tb_fifo_skid_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        fifo_ready;
  logic [1:0]  level;
  logic [15:0] wr_count;

  // Small-counter instance: always streaming, used for the saturation check.
  logic [7:0]  sat_in_data;
  logic        sat_in_valid;
  logic        sat_in_ready;
  logic [7:0]  sat_wr_data;
  logic        sat_wr_en;
  logic        sat_full;
  logic        sat_ready;
  logic [1:0]  sat_level;
  logic [3:0]  sat_wr_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]  exp_q[$];
  logic        exp_ready = 1'b0;
  logic [15:0] exp_count = '0;

  fifo_skid_writer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .fifo_ready   (fifo_ready),
    .level        (level),
    .wr_count     (wr_count)
  );

  fifo_skid_writer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (sat_in_data),
    .in_valid     (sat_in_valid),
    .in_ready     (sat_in_ready),
    .fifo_wr_data (sat_wr_data),
    .fifo_wr_en   (sat_wr_en),
    .fifo_full    (sat_full),
    .fifo_ready   (sat_ready),
    .level        (sat_level),
    .wr_count     (sat_wr_count)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard/monitor: the model is simply the ordered list of words held.
  // A push appends, a write removes the oldest; ready is "not full after this edge".
  always @(negedge clk) begin
    logic exp_wr;
    if (!rst_n) begin
      exp_q.delete();
      exp_count = '0;
      exp_ready = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_wr_en",    {31'd0, fifo_wr_en}, 32'd0);
      check("rst_level",    {30'd0, level}, 32'd0);
      check("rst_wr_count", {16'd0, wr_count}, 32'd0);
      check("rst_wr_data",  {24'd0, fifo_wr_data}, 32'd0);
    end else begin
      exp_wr = (exp_q.size() > 0) && !fifo_full && fifo_ready;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("level",    {30'd0, level}, exp_q.size());
      check("wr_en",    {31'd0, fifo_wr_en}, {31'd0, exp_wr});
      check("wr_count", {16'd0, wr_count}, {16'd0, exp_count});
      if (exp_wr) begin
        check("wr_data", {24'd0, fifo_wr_data}, {24'd0, exp_q[0]});
        void'(exp_q.pop_front());
        if (exp_count != 16'hFFFF) exp_count++;
      end
      if (in_valid && exp_ready) exp_q.push_back(in_data);
      exp_ready = (exp_q.size() != 2);
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic wait_accept();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic do_reset(input logic ready_after);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    fifo_full  = 1'b0;
    fifo_ready = ready_after;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic done;
    rst_n        = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b1;
    fifo_full    = 1'b0;
    fifo_ready   = 1'b1;
    sat_in_data  = 8'h3C;
    sat_in_valid = 1'b1;
    sat_full     = 1'b0;
    sat_ready    = 1'b1;

    // Reset held with in_valid high
    repeat (10) @(posedge clk);
    #1;
    check("reset_hold_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Streaming 0x00..0xFF back to back
    for (int i = 0; i < 256; i++) send(i[7:0]);
    check("stream_level_end", {30'd0, level}, 32'd1);
    @(posedge clk);
    #1;
    check("stream_count", {16'd0, wr_count}, 32'd256);

    // Backpressure: A1 to head, A2 to skid, A3 waits
    fifo_full = 1'b1;
    send(8'hA1);
    send(8'hA2);
    in_data  = 8'hA3;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_level", {30'd0, level}, 32'd2);
    check("bp_ready", {31'd0, in_ready}, 32'd0);
    check("bp_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_accept();
    repeat (3) @(posedge clk);
    #1;
    check("bp_count", {16'd0, wr_count}, 32'd259);

    // FIFO not ready after reset
    do_reset(1'b0);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    check("nr_level", {30'd0, level}, 32'd2);
    check("nr_count", {16'd0, wr_count}, 32'd0);
    @(posedge clk);
    #1;
    fifo_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("nr_count_after", {16'd0, wr_count}, 32'd2);

    // Random stream: sparse in_valid, random full
    do_reset(1'b1);
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1024; n++) begin
          while ($urandom_range(0, 9) != 0) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom_range(0, 255)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          fifo_full = ($urandom_range(0, 3) == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    fifo_full = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rand_count", {16'd0, wr_count}, 32'd1024);
    check("rand_drained", exp_q.size(), 32'd0);

    // Reset asserted between edges while two words are held
    fifo_full = 1'b1;
    send(8'hC1);
    send(8'hC2);
    @(negedge clk);
    check("mr_level_before", {30'd0, level}, 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_ready", {31'd0, in_ready}, 32'd0);
    check("mr_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("mr_level", {30'd0, level}, 32'd0);
    check("mr_data",  {24'd0, fifo_wr_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    fifo_full = 1'b0;
    rst_n     = 1'b1;
    send(8'h5A);
    send(8'h5B);
    repeat (4) @(posedge clk);
    #1;
    check("mr_count_after", {16'd0, wr_count}, 32'd2);

    // Saturating 4-bit counter, streaming since the last reset
    repeat (30) @(posedge clk);
    #1;
    check("sat_count", {28'd0, sat_wr_count}, 32'd15);
    check("sat_wr_en", {31'd0, sat_wr_en}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("sat_count_hold", {28'd0, sat_wr_count}, 32'd15);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
